// File: rtl/cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_clock_ctrl
//
// Generates the CPU advance enable for a soft CPU. The CPU either free-runs at
// one of two rates or advances one instruction per debounced button press. A
// halt request from the CPU stops it until the run switch is returned to
// single-step.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst_n      in   asynchronous active-low reset
//   run_sw     in   async switch: 1 = free run, 0 = single step
//   speed_sw   in   async switch: 0 = FAST_DIV period, 1 = SLOW_DIV period
//   step_btn   in   raw bouncing pushbutton, active-high
//   halt_in    in   synchronous halt request from the CPU
//   cpu_en     out  one-cycle CPU advance enable (registered)
//   tick_count out  number of cpu_en pulses since reset (wraps)
//   state      out  00 STEP, 01 RUN, 10 HALT
// -----------------------------------------------------------------------------
module cpu_clock_ctrl #(
  parameter int unsigned FAST_DIV  = 1,
  parameter int unsigned SLOW_DIV  = 50_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_sw,
  input  logic        speed_sw,
  input  logic        step_btn,
  input  logic        halt_in,
  output logic        cpu_en,
  output logic [31:0] tick_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_STEP = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  // The debounce counter only has to reach DB_CYCLES-1.
  localparam int unsigned DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [31:0]     FAST_LAST = 32'(FAST_DIV - 1);
  localparam logic [31:0]     SLOW_LAST = 32'(SLOW_DIV - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic run_meta_q,   run_sync_q;
  logic speed_meta_q, speed_sync_q;
  logic step_meta_q,  step_sync_q;

  // NOTE: every flop resets asynchronously so the outputs drop the instant
  // rst_n falls, even with the clock mid-period; state uses non-blocking
  // assignments so all flops see pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta_q   <= 1'b0;
      run_sync_q   <= 1'b0;
      speed_meta_q <= 1'b0;
      speed_sync_q <= 1'b0;
      step_meta_q  <= 1'b0;
      step_sync_q  <= 1'b0;
    end else begin
      run_meta_q   <= run_sw;
      run_sync_q   <= run_meta_q;
      speed_meta_q <= speed_sw;
      speed_sync_q <= speed_meta_q;
      step_meta_q  <= step_btn;
      step_sync_q  <= step_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Step button debounce and rising-edge request
  // ---------------------------------------------------------------------------
  logic            db_level_q;
  logic [DB_W-1:0] db_cnt_q;
  logic            step_req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      step_req_q <= 1'b0;
    end else begin
      step_req_q <= 1'b0;
      if (step_sync_q != db_level_q) begin
        if (db_cnt_q == DB_LAST) begin
          // Accept the new level; a request only on a press, not a release.
          db_level_q <= step_sync_q;
          db_cnt_q   <= '0;
          step_req_q <= step_sync_q;
        end else begin
          db_cnt_q <= db_cnt_q + DB_W'(1);
        end
      end else begin
        db_cnt_q <= '0;   // any glitch back to the accepted level restarts
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM, prescaler and tick counter
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic [31:0] presc_q;
  logic        speed_prev_q;
  logic        cpu_en_q;
  logic [31:0] tick_q;

  logic        speed_chg;
  logic [31:0] div_last;
  logic        terminal;
  logic        fire;

  assign speed_chg = speed_sync_q ^ speed_prev_q;
  assign div_last  = speed_sync_q ? SLOW_LAST : FAST_LAST;
  // A speed change clears the prescaler, so it also cancels a coincident count.
  assign terminal  = (presc_q == div_last) && !speed_chg;

  // NOTE: fire gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    fire = 1'b0;
    case (state_q)
      ST_STEP: fire = step_req_q & ~halt_in;
      ST_RUN:  fire = run_sync_q & ~halt_in & terminal;
      default: fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_STEP;
      presc_q      <= '0;
      speed_prev_q <= 1'b0;
      cpu_en_q     <= 1'b0;
      tick_q       <= '0;
    end else begin
      speed_prev_q <= speed_sync_q;
      cpu_en_q     <= fire;
      if (fire) tick_q <= tick_q + 32'd1;

      case (state_q)
        ST_STEP: begin
          presc_q <= '0;   // RUN is always entered with a fresh prescaler
          if (halt_in)         state_q <= ST_HALT;
          else if (run_sync_q) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (halt_in) begin
            state_q <= ST_HALT;
            presc_q <= '0;
          end else if (!run_sync_q) begin
            state_q <= ST_STEP;
            presc_q <= '0;
          end else if (speed_chg || terminal) begin
            presc_q <= '0;
          end else begin
            presc_q <= presc_q + 32'd1;
          end
        end
        ST_HALT: begin
          presc_q <= '0;
          // Only dropping the run switch leaves HALT; steps are ignored here.
          if (!run_sync_q) state_q <= ST_STEP;
        end
        default: begin
          state_q <= ST_STEP;
          presc_q <= '0;
        end
      endcase
    end
  end

  assign cpu_en     = cpu_en_q;
  assign tick_count = tick_q;
  assign state      = state_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_clock_ctrl
//
// Bench for cpu_clock_ctrl with FAST_DIV=1, SLOW_DIV=4, DB_CYCLES=3. Inputs
// are driven after the falling edge and outputs compared at the next falling
// edge. A behavioural model (input delay queues, run-length debounce, modulo
// phase counter) predicts outputs for the randomized section.
// -----------------------------------------------------------------------------
module tb_cpu_clock_ctrl;

  localparam int FAST = 1;
  localparam int SLOW = 4;
  localparam int DB   = 3;

  localparam logic [1:0] S_STEP = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_sw = 1'b0;
  logic        speed_sw = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt_in = 1'b0;
  logic        cpu_en;
  logic [31:0] tick_count;
  logic [1:0]  state;

  cpu_clock_ctrl #(
    .FAST_DIV (FAST),
    .SLOW_DIV (SLOW),
    .DB_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_sw    (run_sw),
    .speed_sw  (speed_sw),
    .step_btn  (step_btn),
    .halt_in   (halt_in),
    .cpu_en    (cpu_en),
    .tick_count(tick_count),
    .state     (state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic        mq_run[$];
  logic        mq_spd[$];
  logic        mq_btn[$];
  logic [1:0]  m_state;
  int          m_phase;
  logic        m_spd_prev;
  logic        m_db_level;
  int          m_db_run;
  logic        m_req_pending;
  logic        m_en;
  logic [31:0] m_tick;

  task automatic model_reset();
    mq_run = '{1'b0, 1'b0};
    mq_spd = '{1'b0, 1'b0};
    mq_btn = '{1'b0, 1'b0};
    m_state = S_STEP;
    m_phase = 0;
    m_spd_prev = 1'b0;
    m_db_level = 1'b0;
    m_db_run = 0;
    m_req_pending = 1'b0;
    m_en = 1'b0;
    m_tick = 32'd0;
  endtask

  // Predicts the outputs after the next rising edge given the pin values.
  task automatic model_step(input logic r, input logic s, input logic b, input logic h);
    logic rs, ss, bs, req, fire;
    int div;
    rs = mq_run.pop_front(); mq_run.push_back(r);
    ss = mq_spd.pop_front(); mq_spd.push_back(s);
    bs = mq_btn.pop_front(); mq_btn.push_back(b);
    req = m_req_pending;
    m_req_pending = 1'b0;
    if (bs != m_db_level) begin
      m_db_run++;
      if (m_db_run == DB) begin
        m_db_level = bs;
        m_db_run = 0;
        if (bs) m_req_pending = 1'b1;
      end
    end else begin
      m_db_run = 0;
    end
    fire = 1'b0;
    if (m_state == S_STEP) begin
      if (h) m_state = S_HALT;
      else begin
        fire = req;
        if (rs) begin m_state = S_RUN; m_phase = 0; end
      end
    end else if (m_state == S_RUN) begin
      if (h) m_state = S_HALT;
      else if (!rs) m_state = S_STEP;
      else if (ss != m_spd_prev) m_phase = 0;
      else begin
        div = ss ? SLOW : FAST;
        if ((m_phase + 1) % div == 0) fire = 1'b1;
        m_phase = (m_phase + 1) % div;
      end
    end else begin
      if (!rs) m_state = S_STEP;
    end
    m_spd_prev = ss;
    m_en = fire;
    if (fire) m_tick = m_tick + 32'd1;
  endtask

  // One clock: drive pins, step the model, land on the next falling edge.
  task automatic cycle(input logic r, input logic s, input logic b, input logic h);
    run_sw = r; speed_sw = s; step_btn = b; halt_in = h;
    model_step(r, s, b, h);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run_sw = 1'b0; speed_sw = 1'b0; step_btn = 1'b0; halt_in = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press(input int hi, input int lo);
    for (int i = 0; i < hi; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < lo; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: run-entry latency, fast run, halt, halt exit
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        run;
    logic        speed;
    logic        btn;
    logic        halt;
    logic [1:0]  exp_state;
    logic        exp_en;
    logic [31:0] exp_tick;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int gap_err, pulses, last, first;
    logic r, s, b, h;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, S_STEP, 1'b0, 32'd0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, S_STEP, 1'b0, 32'd0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, S_RUN,  1'b0, 32'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, S_RUN,  1'b1, 32'd1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, S_RUN,  1'b1, 32'd2};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, S_HALT, 1'b0, 32'd2};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, S_HALT, 1'b0, 32'd2};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, S_HALT, 1'b0, 32'd2};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, S_HALT, 1'b0, 32'd2};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, S_STEP, 1'b0, 32'd2};

    // Reset values
    do_reset();
    check("reset_state", 32'(state), 32'(S_STEP));
    check("reset_cpu_en", 32'(cpu_en), 32'd0);
    check("reset_tick", tick_count, 32'd0);

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].run, vecs[i].speed, vecs[i].btn, vecs[i].halt);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_cpu_en", i), 32'(cpu_en), 32'(vecs[i].exp_en));
      check($sformatf("vec%0d_tick", i), tick_count, vecs[i].exp_tick);
    end

    // Slow run: pulse every 4th cycle
    do_reset();
    gap_err = 0; pulses = 0; last = -1; first = -1;
    for (int c = 1; c <= 40; c++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      if (cpu_en === 1'b1) begin
        if (last >= 0 && (c - last) != SLOW) gap_err++;
        if (first < 0) first = c;
        last = c;
        pulses++;
      end
    end
    check("slow_first_pulse_cycle", 32'(first), 32'd7);
    check("slow_gap_errors", 32'(gap_err), 32'd0);
    check("slow_tick_eq_pulses", tick_count, 32'(pulses));
    check("slow_tick_near_10", 32'((tick_count >= 32'd9) && (tick_count <= 32'd11)), 32'd1);
    check("slow_state", 32'(state), 32'(S_RUN));

    // Bouncing button then held: exactly one pulse
    do_reset();
    pulses = 0; first = -1;
    for (int c = 1; c <= 24; c++) begin
      b = (c <= 4) ? ((c % 2) == 1) : (c <= 14);
      cycle(1'b0, 1'b0, b, 1'b0);
      if (cpu_en === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    check("bounce_pulses", 32'(pulses), 32'd1);
    check("bounce_pulse_cycle", 32'(first), 32'd10);
    check("bounce_tick", tick_count, 32'd1);

    // Halt coinciding with a slow-run terminal count
    do_reset();
    for (int c = 1; c <= 10; c++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("halt_tc_pre_tick", tick_count, 32'd1);
    check("halt_tc_pre_en", 32'(cpu_en), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("halt_tc_en", 32'(cpu_en), 32'd0);
    check("halt_tc_tick", tick_count, 32'd1);
    check("halt_tc_state", 32'(state), 32'(S_HALT));
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      check("halt_hold_en", 32'(cpu_en), 32'd0);
    end
    check("halt_hold_state", 32'(state), 32'(S_HALT));

    // tick_count wrap
    do_reset();
    force dut.tick_q = 32'hFFFF_FFFE;
    #1;
    release dut.tick_q;
    check("wrap_preload", tick_count, 32'hFFFF_FFFE);
    @(negedge clk);
    press(8, 8);
    check("wrap_first_step", tick_count, 32'hFFFF_FFFF);
    press(8, 8);
    check("wrap_second_step", tick_count, 32'h0000_0000);

    // Asynchronous reset mid-run, then re-synchronized start
    do_reset();
    for (int c = 0; c < 8; c++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("midrun_en_before", 32'(cpu_en), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_en", 32'(cpu_en), 32'd0);
    check("async_rst_tick", tick_count, 32'd0);
    check("async_rst_state", 32'(state), 32'(S_STEP));
    @(negedge clk);
    @(negedge clk);
    check("async_rst_no_trailing_en", 32'(cpu_en), 32'd0);
    model_reset();
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("resync_c1_state", 32'(state), 32'(S_STEP));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("resync_c2_state", 32'(state), 32'(S_STEP));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("resync_c3_state", 32'(state), 32'(S_RUN));

    // Randomized run against the model
    do_reset();
    r = 1'b0; s = 1'b0; b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) r = ~r;
      if ($urandom_range(29) == 0) s = ~s;
      if ($urandom_range(5) == 0)  b = ~b;
      h = ($urandom_range(59) == 0);
      cycle(r, s, b, h);
      check("rnd_cpu_en", 32'(cpu_en), 32'(m_en));
      check("rnd_tick", tick_count, m_tick);
      check("rnd_state", 32'(state), 32'(m_state));
      check("rnd_no_en_in_halt", 32'((state == S_HALT) && (cpu_en == 1'b1)), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_clock_ctrl.md
CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 Parameter FAST_DIV, default 1: cpu_en period in fast run, in clk cycles; must be at least 1.
REQ-002 Parameter SLOW_DIV, default 50_000_000: cpu_en period in slow run, in clk cycles; must be at least 1.
REQ-003 Parameter DB_CYCLES, default 1_000_000: number of consecutive stable synchronized cycles needed to accept a step_btn level change.
REQ-004 clk  input  1  system clock, 100 MHz; all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 run_sw  input  1  asynchronous switch; 1 = free-run request, 0 = single-step mode.
REQ-007 speed_sw  input  1  asynchronous switch; 0 = FAST_DIV, 1 = SLOW_DIV.
REQ-008 step_btn  input  1  raw pushbutton, asynchronous and bouncing; active-high.
REQ-009 halt_in  input  1  synchronous CPU halt request (syscall/exit); sampled every cycle.
REQ-010 cpu_en  output  1  one-clk-wide CPU advance enable, registered.
REQ-011 tick_count  output  32  count of cpu_en pulses issued since reset.
REQ-012 state  output  2  current state: 00 STEP, 01 RUN, 10 HALT.

Function
REQ-013 run_sw, speed_sw and step_btn SHALL each pass through a 2-FF synchronizer before use.
REQ-014 Debounce: the debounced step level SHALL change only after the synchronized step_btn has differed from it for DB_CYCLES consecutive cycles; any glitch restarts the count.
REQ-015 A step request SHALL be a 1-cycle pulse on each 0->1 transition of the debounced level; a held button SHALL give exactly one request.
REQ-016 Prescaler: a 32-bit counter SHALL run only in RUN; when it equals the divisor-1, cpu_en SHALL be 1 on the next cycle and the counter SHALL return to 0.
REQ-017 Divisor selection: divisor = FAST_DIV when synchronized speed_sw = 0, otherwise SLOW_DIV; any change of synchronized speed_sw SHALL clear the prescaler.
REQ-018 With FAST_DIV = 1 in RUN, cpu_en SHALL be held high every cycle.
REQ-019 Transition STEP->RUN: synchronized run_sw = 1 and halt_in = 0; the prescaler SHALL start at 0 on entry.
REQ-020 Transition RUN->STEP: synchronized run_sw = 0; cpu_en SHALL be 0 from the cycle after the transition.
REQ-021 Transition RUN or STEP->HALT: halt_in = 1; it has priority over all other transitions.
REQ-022 Transition HALT->STEP: synchronized run_sw = 0 only; step requests and run_sw = 1 SHALL be ignored in HALT.
REQ-023 In STEP, each step request SHALL produce exactly one cpu_en pulse on the following cycle.
REQ-024 Simultaneous halt_in = 1 with a pending prescaler terminal count or step request SHALL suppress that cpu_en pulse and enter HALT.
REQ-025 cpu_en SHALL never be 1 while state = HALT.
REQ-026 tick_count SHALL increment by 1 in the cycle cpu_en = 1 and wrap from 0xFFFFFFFF to 0.
REQ-027 A run_sw edge at the pin SHALL be reflected on state no later than 3 clk edges afterwards.

Reset
REQ-028 While rst_n = 0: state = STEP, cpu_en = 0, tick_count = 0, prescaler = 0, synchronizers = 0, debounced level = 0, debounce counter = 0.
REQ-029 Reset asserted mid-RUN or mid-debounce SHALL abort the operation immediately, with no trailing cpu_en pulse.
REQ-030 After rst_n is released, the first state transition SHALL occur only from the re-synchronized inputs.

Verification (use FAST_DIV=1, SLOW_DIV=4, DB_CYCLES=3)
REQ-031 run_sw=1, speed_sw=1, for 40 cycles -> cpu_en pulses exactly every 4th cycle; tick_count=10 (within ±1 of entry alignment); state=01.
REQ-032 STEP mode, step_btn bounces 1-0-1-0 at 1-cycle intervals and is then held high for 10 cycles -> exactly one cpu_en pulse; tick_count += 1.
REQ-033 RUN fast, halt_in pulsed 1 cycle -> state=10 on the next edge; cpu_en=0 thereafter; run_sw toggle 1->0 -> state=00.
REQ-034 halt_in=1 in the same cycle as a prescaler terminal count -> no cpu_en; tick_count unchanged.
REQ-035 tick_count preloaded to 0xFFFFFFFE, then 2 steps -> value 0xFFFFFFFF, then 0x00000000.
REQ-036 rst_n driven low asynchronously mid-RUN, between clk edges -> cpu_en and tick_count are 0 immediately; state=00.
